// File: rtl/zx_keymatrix_pkg.sv
// rtl/zx_keymatrix_pkg.sv - shared constants, scancode decode and combo tables for zx_keymatrix
//
// Contents:
//   row/column index constants and matrix position helper
//   decode_key()     : {ext, set-2 code} -> {hit, 6-bit matrix index}
//   combo_e          : composite-key identifiers
//   combo_expand()   : combo flags -> 40-bit matrix contribution
//   hotkey and modifier scancode constants
// The combo tables are only referenced when ZXKM_COMBO_EN is defined.
package zx_keymatrix_pkg;

  localparam int NUM_ROWS   = 8;
  localparam int NUM_COLS   = 5;
  localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;
  localparam int NUM_COMBOS = 8;

  // Row n corresponds to CPU address line A(8+n).
  localparam int ROW_A8  = 0;
  localparam int ROW_A9  = 1;
  localparam int ROW_A10 = 2;
  localparam int ROW_A11 = 3;
  localparam int ROW_A12 = 4;
  localparam int ROW_A13 = 5;
  localparam int ROW_A14 = 6;
  localparam int ROW_A15 = 7;

  localparam int COL_0 = 0;
  localparam int COL_1 = 1;
  localparam int COL_2 = 2;
  localparam int COL_3 = 3;
  localparam int COL_4 = 4;

  typedef logic [5:0] key_idx_t;

  typedef struct packed {
    logic     hit;
    key_idx_t index;
  } key_pos_t;

  // Flat matrix index: row * 5 + column.
  function automatic key_idx_t key_pos(input int r, input int c);
    return key_idx_t'(r * NUM_COLS + c);
  endfunction

  localparam key_idx_t IDX_CAPS  = key_pos(ROW_A8,  COL_0);
  localparam key_idx_t IDX_5     = key_pos(ROW_A11, COL_4);
  localparam key_idx_t IDX_0     = key_pos(ROW_A12, COL_0);
  localparam key_idx_t IDX_8     = key_pos(ROW_A12, COL_2);
  localparam key_idx_t IDX_7     = key_pos(ROW_A12, COL_3);
  localparam key_idx_t IDX_6     = key_pos(ROW_A12, COL_4);
  localparam key_idx_t IDX_SPACE = key_pos(ROW_A15, COL_0);
  localparam key_idx_t IDX_SYM   = key_pos(ROW_A15, COL_1);
  localparam key_idx_t IDX_M     = key_pos(ROW_A15, COL_2);
  localparam key_idx_t IDX_N     = key_pos(ROW_A15, COL_3);

  // Modifier and hotkey scancodes.
  localparam logic [7:0] CODE_CTRL = 8'h14;  // left plain, right with E0
  localparam logic [7:0] CODE_ALT  = 8'h11;  // left plain, right with E0
  localparam logic [7:0] CODE_F5   = 8'h03;
  localparam logic [7:0] CODE_DEL  = 8'h71;  // E0-prefixed

  // Composite-key scancodes.
  localparam logic [7:0] CODE_BKSP   = 8'h66;
  localparam logic [7:0] CODE_LEFT   = 8'h6B;  // E0
  localparam logic [7:0] CODE_DOWN   = 8'h72;  // E0
  localparam logic [7:0] CODE_UP     = 8'h75;  // E0
  localparam logic [7:0] CODE_RIGHT  = 8'h74;  // E0
  localparam logic [7:0] CODE_ESC    = 8'h76;
  localparam logic [7:0] CODE_COMMA  = 8'h41;
  localparam logic [7:0] CODE_PERIOD = 8'h49;

  // Bit positions in the modifier and hotkey flag vectors.
  localparam int MOD_CTRL_L = 0;
  localparam int MOD_CTRL_R = 1;
  localparam int MOD_ALT_L  = 2;
  localparam int MOD_ALT_R  = 3;
  localparam int HOT_F5     = 0;
  localparam int HOT_DEL    = 1;

  typedef enum logic [2:0] {
    CMB_BKSP,
    CMB_LEFT,
    CMB_DOWN,
    CMB_UP,
    CMB_RIGHT,
    CMB_ESC,
    CMB_COMMA,
    CMB_PERIOD
  } combo_e;

  // Physical key map. Only right ctrl is meaningful with the E0 prefix.
  function automatic key_pos_t decode_key(input logic ext, input logic [7:0] code);
    key_pos_t p;
    p.hit   = 1'b1;
    p.index = '0;
    if (ext) begin
      p.hit   = (code == CODE_CTRL);
      p.index = IDX_SYM;
    end else begin
      case (code)
        8'h12, 8'h59: p.index = IDX_CAPS;
        8'h1A: p.index = key_pos(ROW_A8,  COL_1);  // Z
        8'h22: p.index = key_pos(ROW_A8,  COL_2);  // X
        8'h21: p.index = key_pos(ROW_A8,  COL_3);  // C
        8'h2A: p.index = key_pos(ROW_A8,  COL_4);  // V
        8'h1C: p.index = key_pos(ROW_A9,  COL_0);  // A
        8'h1B: p.index = key_pos(ROW_A9,  COL_1);  // S
        8'h23: p.index = key_pos(ROW_A9,  COL_2);  // D
        8'h2B: p.index = key_pos(ROW_A9,  COL_3);  // F
        8'h34: p.index = key_pos(ROW_A9,  COL_4);  // G
        8'h15: p.index = key_pos(ROW_A10, COL_0);  // Q
        8'h1D: p.index = key_pos(ROW_A10, COL_1);  // W
        8'h24: p.index = key_pos(ROW_A10, COL_2);  // E
        8'h2D: p.index = key_pos(ROW_A10, COL_3);  // R
        8'h2C: p.index = key_pos(ROW_A10, COL_4);  // T
        8'h16: p.index = key_pos(ROW_A11, COL_0);  // 1
        8'h1E: p.index = key_pos(ROW_A11, COL_1);  // 2
        8'h26: p.index = key_pos(ROW_A11, COL_2);  // 3
        8'h25: p.index = key_pos(ROW_A11, COL_3);  // 4
        8'h2E: p.index = IDX_5;
        8'h45: p.index = IDX_0;
        8'h46: p.index = key_pos(ROW_A12, COL_1);  // 9
        8'h3E: p.index = IDX_8;
        8'h3D: p.index = IDX_7;
        8'h36: p.index = IDX_6;
        8'h4D: p.index = key_pos(ROW_A13, COL_0);  // P
        8'h44: p.index = key_pos(ROW_A13, COL_1);  // O
        8'h43: p.index = key_pos(ROW_A13, COL_2);  // I
        8'h3C: p.index = key_pos(ROW_A13, COL_3);  // U
        8'h35: p.index = key_pos(ROW_A13, COL_4);  // Y
        8'h5A: p.index = key_pos(ROW_A14, COL_0);  // ENTER
        8'h4B: p.index = key_pos(ROW_A14, COL_1);  // L
        8'h42: p.index = key_pos(ROW_A14, COL_2);  // K
        8'h3B: p.index = key_pos(ROW_A14, COL_3);  // J
        8'h33: p.index = key_pos(ROW_A14, COL_4);  // H
        8'h29: p.index = IDX_SPACE;
        8'h14: p.index = IDX_SYM;
        8'h3A: p.index = IDX_M;
        8'h31: p.index = IDX_N;
        8'h32: p.index = key_pos(ROW_A15, COL_4);  // B
        default: p.hit = 1'b0;
      endcase
    end
    return p;
  endfunction

  // Matrix positions pressed by one composite key.
  function automatic logic [NUM_KEYS-1:0] combo_keys(input combo_e c);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    case (c)
      CMB_BKSP:   begin m[IDX_CAPS] = 1'b1; m[IDX_0]     = 1'b1; end
      CMB_LEFT:   begin m[IDX_CAPS] = 1'b1; m[IDX_5]     = 1'b1; end
      CMB_DOWN:   begin m[IDX_CAPS] = 1'b1; m[IDX_6]     = 1'b1; end
      CMB_UP:     begin m[IDX_CAPS] = 1'b1; m[IDX_7]     = 1'b1; end
      CMB_RIGHT:  begin m[IDX_CAPS] = 1'b1; m[IDX_8]     = 1'b1; end
      CMB_ESC:    begin m[IDX_CAPS] = 1'b1; m[IDX_SPACE] = 1'b1; end
      CMB_COMMA:  begin m[IDX_SYM]  = 1'b1; m[IDX_N]     = 1'b1; end
      CMB_PERIOD: begin m[IDX_SYM]  = 1'b1; m[IDX_M]     = 1'b1; end
      default:    m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [NUM_KEYS-1:0] combo_expand(input logic [NUM_COMBOS-1:0] active);
    logic [NUM_KEYS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_COMBOS; i++) begin
      if (active[i]) m = m | combo_keys(combo_e'(3'(i)));
    end
    return m;
  endfunction

endpackage

// File: rtl/zx_keymatrix_decode.sv
// rtl/zx_keymatrix_decode.sv - combinational scancode classifier for zx_keymatrix
//
// Ports:
//   kext, kcode   in   E0 flag and set-2 scancode of the event
//   hit, index    out  event maps to matrix position index (0..39)
//   combo_hit     out  event is a composite key (ZXKM_COMBO_EN only)
//   combo_id      out  which composite key (ZXKM_COMBO_EN only)
//   is_mod        out  one-hot {alt_r, alt_l, ctrl_r, ctrl_l}
//   is_hotkey     out  {del, f5}
// Macro: ZXKM_COMBO_EN enables the composite-key outputs.
module zx_keymatrix_decode
  import zx_keymatrix_pkg::*;
(
  input  logic       kext,
  input  logic [7:0] kcode,
  output logic       hit,
  output key_idx_t   index,
`ifdef ZXKM_COMBO_EN
  output logic       combo_hit,
  output combo_e     combo_id,
`endif
  output logic [3:0] is_mod,
  output logic [1:0] is_hotkey
);

  key_pos_t pos;

  assign pos   = decode_key(kext, kcode);
  assign hit   = pos.hit;
  assign index = pos.index;

  always_comb begin
    is_mod                = '0;
    is_mod[MOD_CTRL_L]    = !kext && (kcode == CODE_CTRL);
    is_mod[MOD_CTRL_R]    =  kext && (kcode == CODE_CTRL);
    is_mod[MOD_ALT_L]     = !kext && (kcode == CODE_ALT);
    is_mod[MOD_ALT_R]     =  kext && (kcode == CODE_ALT);
    is_hotkey             = '0;
    is_hotkey[HOT_F5]     = !kext && (kcode == CODE_F5);
    is_hotkey[HOT_DEL]    =  kext && (kcode == CODE_DEL);
  end

`ifdef ZXKM_COMBO_EN
  always_comb begin
    combo_hit = 1'b1;
    combo_id  = CMB_BKSP;
    case ({kext, kcode})
      {1'b0, CODE_BKSP}:   combo_id = CMB_BKSP;
      {1'b1, CODE_LEFT}:   combo_id = CMB_LEFT;
      {1'b1, CODE_DOWN}:   combo_id = CMB_DOWN;
      {1'b1, CODE_UP}:     combo_id = CMB_UP;
      {1'b1, CODE_RIGHT}:  combo_id = CMB_RIGHT;
      {1'b0, CODE_ESC}:    combo_id = CMB_ESC;
      {1'b0, CODE_COMMA}:  combo_id = CMB_COMMA;
      {1'b0, CODE_PERIOD}: combo_id = CMB_PERIOD;
      default:             combo_hit = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/zx_keymatrix.sv
// rtl/zx_keymatrix.sv - PS/2 set-2 events to ZX Spectrum 8x5 keyboard matrix
//
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-high reset, clears all key state
//   kstrobe   in   one-cycle pulse per PS/2 event
//   kpress    in   1 = make, 0 = break (with kstrobe)
//   kext      in   E0-prefixed code (with kstrobe)
//   kcode     in   set-2 scancode (with kstrobe)
//   row       in   CPU A[15:8], active-low row select
//   col       out  active-low column data, 5'h1F = no key
//   nmi       out  one-cycle pulse on F5 make (not on autorepeat)
//   rst_req   out  one-cycle pulse on Ctrl+Alt+Del
// Macro: ZXKM_COMBO_EN adds composite keys (arrows, backspace, esc, comma, period).
//
// Stage 1 captures the event; stage 2 decodes it and updates state, so col
// and the pulses move two clocks after kstrobe.
module zx_keymatrix
  import zx_keymatrix_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       kstrobe,
  input  logic       kpress,
  input  logic       kext,
  input  logic [7:0] kcode,
  input  logic [7:0] row,
  output logic [4:0] col,
  output logic       nmi,
  output logic       rst_req
);

  logic                s1_valid;
  logic                s1_press;
  logic                s1_ext;
  logic [7:0]          s1_code;

  logic                d_hit;
  key_idx_t            d_index;
  logic [3:0]          d_is_mod;
  logic [1:0]          d_is_hotkey;

  logic [NUM_KEYS-1:0] keys;
  logic [3:0]          mods;
  logic                f5_held;
  logic                del_held;
  logic                ctrl_held;
  logic                alt_held;

  logic [NUM_KEYS-1:0] eff;
  logic [NUM_COLS-1:0] sel;

`ifdef ZXKM_COMBO_EN
  logic                d_combo_hit;
  combo_e              d_combo_id;
  logic [NUM_COMBOS-1:0] combo;
`endif

  // Stage 1: event capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_press <= 1'b0;
      s1_ext   <= 1'b0;
      s1_code  <= '0;
    end else begin
      s1_valid <= kstrobe;
      if (kstrobe) begin
        s1_press <= kpress;
        s1_ext   <= kext;
        s1_code  <= kcode;
      end
    end
  end

  zx_keymatrix_decode u_decode (
    .kext      (s1_ext),
    .kcode     (s1_code),
    .hit       (d_hit),
    .index     (d_index),
`ifdef ZXKM_COMBO_EN
    .combo_hit (d_combo_hit),
    .combo_id  (d_combo_id),
`endif
    .is_mod    (d_is_mod),
    .is_hotkey (d_is_hotkey)
  );

  assign ctrl_held = mods[MOD_CTRL_L] | mods[MOD_CTRL_R];
  assign alt_held  = mods[MOD_ALT_L]  | mods[MOD_ALT_R];

  // Stage 2: state update. Make sets, break clears, so repeated makes and
  // stray breaks are naturally idempotent. The held flags for F5 and Del
  // suppress autorepeat retriggering of the pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keys     <= '0;
      mods     <= '0;
      f5_held  <= 1'b0;
      del_held <= 1'b0;
      nmi      <= 1'b0;
      rst_req  <= 1'b0;
    end else begin
      nmi     <= 1'b0;
      rst_req <= 1'b0;
      if (s1_valid) begin
        if (d_hit) keys[d_index] <= s1_press;
        mods <= (mods & ~d_is_mod) | (d_is_mod & {4{s1_press}});
        if (d_is_hotkey[HOT_F5]) begin
          if (s1_press && !f5_held) nmi <= 1'b1;
          f5_held <= s1_press;
        end
        if (d_is_hotkey[HOT_DEL]) begin
          if (s1_press && !del_held && ctrl_held && alt_held) rst_req <= 1'b1;
          del_held <= s1_press;
        end
      end
    end
  end

`ifdef ZXKM_COMBO_EN
  // Composite keys live in their own flags and are ORed into the matrix, so
  // releasing one never clears a physically held CAPS or SYM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      combo <= '0;
    end else if (s1_valid && d_combo_hit) begin
      combo[d_combo_id] <= s1_press;
    end
  end

  assign eff = keys | combo_expand(combo);
`else
  assign eff = keys;
`endif

  // Port-FE read: OR the columns of every selected row, then invert.
  always_comb begin
    sel = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row[r]) sel = sel | eff[r*NUM_COLS +: NUM_COLS];
    end
    col = ~sel;
  end

endmodule

// File: tb/tb_zx_keymatrix.sv
// tb/tb_zx_keymatrix.sv - directed self-checking bench for zx_keymatrix
module tb_zx_keymatrix;

  localparam logic MK  = 1'b1;
  localparam logic BR  = 1'b0;
  localparam logic STD = 1'b0;
  localparam logic EXT = 1'b1;

  logic       clock = 1'b0;
  logic       reset;
  logic       kstrobe;
  logic       kpress;
  logic       kext;
  logic [7:0] kcode;
  logic [7:0] row;
  logic [4:0] col;
  logic       nmi;
  logic       rst_req;

  int errors = 0;
  int checks = 0;

  always #10 clock = ~clock;

  zx_keymatrix dut (
    .clock   (clock),
    .reset   (reset),
    .kstrobe (kstrobe),
    .kpress  (kpress),
    .kext    (kext),
    .kcode   (kcode),
    .row     (row),
    .col     (col),
    .nmi     (nmi),
    .rst_req (rst_req)
  );

  task automatic chk_col(input string tag, input logic [4:0] exp);
    checks++;
    assert (col === exp) else begin
      errors++;
      $error("FAIL %s col observed=%h expected=%h", tag, col, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present one event for one clock; returns #1 after the capturing edge.
  task automatic ev(input logic p, input logic e, input logic [7:0] c);
    kstrobe = 1'b1;
    kpress  = p;
    kext    = e;
    kcode   = c;
    @(posedge clock);
    #1;
    kstrobe = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_row(input logic [7:0] r);
    row = r;
    #1;
  endtask

  initial begin
    reset = 1'b1; kstrobe = 1'b0; kpress = 1'b0; kext = 1'b0; kcode = '0; row = 8'hFF;
    repeat (2) @(posedge clock);
    #1;
    set_row(8'h00);
    chk_col("reset_col", 5'h1F);
    chk_bit("reset_nmi", nmi, 1'b0);
    chk_bit("reset_rst_req", rst_req, 1'b0);
    reset = 1'b0;
    tick();

    // Single key A on row A9, with latency and row selection.
    set_row(8'hFD);
    ev(MK, STD, 8'h1C);
    chk_col("a_latency", 5'h1F);
    tick();
    chk_col("a_press", 5'h1E);
    set_row(8'hFB);
    chk_col("a_other_row", 5'h1F);
    set_row(8'hFF);
    chk_col("a_row_ff", 5'h1F);
    set_row(8'hFD);
    ev(MK, STD, 8'h1C);
    tick();
    chk_col("a_repeat_make", 5'h1E);
    ev(BR, STD, 8'h1C);
    tick();
    chk_col("a_break", 5'h1F);

    // Back-to-back strobes applied in order.
    ev(MK, STD, 8'h1C);
    ev(MK, STD, 8'h1B);
    tick();
    chk_col("b2b_press", 5'h1C);
    ev(BR, STD, 8'h1C);
    ev(MK, STD, 8'h23);
    ev(BR, STD, 8'h1B);
    tick();
    chk_col("b2b_order", 5'h1B);
    ev(BR, STD, 8'h23);
    ev(BR, STD, 8'h1B);
    tick();
    chk_col("b2b_stray_break", 5'h1F);

    // Shift + Z, both shift codes.
    set_row(8'hFE);
    ev(MK, STD, 8'h12);
    ev(MK, STD, 8'h1A);
    tick();
    chk_col("shift_z", 5'h1C);
    ev(BR, STD, 8'h12);
    tick();
    chk_col("shift_release", 5'h1D);
    ev(MK, STD, 8'h59);
    tick();
    chk_col("rshift_z", 5'h1C);
    ev(BR, STD, 8'h59);
    ev(BR, STD, 8'h1A);
    tick();
    chk_col("shift_z_clear", 5'h1F);

    // Several rows selected at once: A (A9 bit0) and R (A10 bit3).
    set_row(8'hF9);
    ev(MK, STD, 8'h1C);
    ev(MK, STD, 8'h2D);
    tick();
    chk_col("multi_row", 5'h16);
    set_row(8'hFD);
    chk_col("multi_row_a9", 5'h1E);
    set_row(8'h00);
    chk_col("multi_row_all", 5'h16);
    ev(BR, STD, 8'h1C);
    ev(BR, STD, 8'h2D);
    tick();
    chk_col("multi_row_clear", 5'h1F);

    // Right ctrl -> SYM, space, enter.
    set_row(8'h7F);
    ev(MK, EXT, 8'h14);
    tick();
    chk_col("rctrl_sym", 5'h1D);
    ev(MK, STD, 8'h29);
    tick();
    chk_col("sym_space", 5'h1C);
    ev(BR, EXT, 8'h14);
    ev(BR, STD, 8'h29);
    tick();
    set_row(8'hBF);
    ev(MK, STD, 8'h5A);
    tick();
    chk_col("enter", 5'h1E);
    ev(BR, STD, 8'h5A);
    tick();

    // Unmapped codes (and extended A) leave the matrix alone.
    set_row(8'h00);
    ev(MK, STD, 8'h0E);
    ev(MK, EXT, 8'h1C);
`ifndef ZXKM_COMBO_EN
    ev(MK, STD, 8'h66);
    ev(MK, EXT, 8'h6B);
    ev(MK, STD, 8'h41);
`endif
    tick();
    tick();
    chk_col("unmapped", 5'h1F);
    ev(BR, STD, 8'h0E);
    ev(BR, EXT, 8'h1C);
    tick();

    // NMI on F5 with autorepeat suppression.
    ev(MK, STD, 8'h03);
    chk_bit("nmi_early", nmi, 1'b0);
    tick();
    chk_bit("nmi_pulse", nmi, 1'b1);
    chk_bit("nmi_no_rst", rst_req, 1'b0);
    tick();
    chk_bit("nmi_one_clock", nmi, 1'b0);
    ev(MK, STD, 8'h03);
    tick();
    chk_bit("nmi_repeat1", nmi, 1'b0);
    ev(MK, STD, 8'h03);
    tick();
    chk_bit("nmi_repeat2", nmi, 1'b0);
    ev(BR, STD, 8'h03);
    tick();
    chk_bit("nmi_break", nmi, 1'b0);
    ev(MK, STD, 8'h03);
    tick();
    chk_bit("nmi_again", nmi, 1'b1);
    tick();
    chk_bit("nmi_again_end", nmi, 1'b0);
    ev(BR, STD, 8'h03);
    tick();

    // Ctrl+Alt+Del reset request.
    ev(MK, STD, 8'h14);
    ev(MK, STD, 8'h11);
    ev(MK, EXT, 8'h71);
    chk_bit("rst_early", rst_req, 1'b0);
    tick();
    chk_bit("rst_pulse", rst_req, 1'b1);
    tick();
    chk_bit("rst_one_clock", rst_req, 1'b0);
    ev(MK, EXT, 8'h71);
    tick();
    chk_bit("rst_del_held", rst_req, 1'b0);
    ev(BR, EXT, 8'h71);
    ev(BR, STD, 8'h11);
    tick();
    ev(MK, EXT, 8'h71);
    tick();
    chk_bit("rst_ctrl_only", rst_req, 1'b0);
    ev(BR, EXT, 8'h71);
    ev(MK, EXT, 8'h11);
    tick();
    ev(MK, EXT, 8'h71);
    tick();
    chk_bit("rst_right_alt", rst_req, 1'b1);
    ev(BR, EXT, 8'h71);
    ev(BR, EXT, 8'h11);
    ev(MK, EXT, 8'h14);
    ev(BR, STD, 8'h14);
    ev(MK, STD, 8'h11);
    ev(MK, EXT, 8'h71);
    tick();
    chk_bit("rst_right_ctrl", rst_req, 1'b1);
    ev(BR, EXT, 8'h71);
    ev(BR, STD, 8'h11);
    ev(BR, EXT, 8'h14);
    tick();

`ifdef ZXKM_COMBO_EN
    // Combo keys: release never drops a physically held CAPS or SYM.
    set_row(8'hFE);
    ev(MK, STD, 8'h12);
    ev(MK, EXT, 8'h6B);
    tick();
    chk_col("cmb_left_caps", 5'h1E);
    set_row(8'hF7);
    chk_col("cmb_left_5", 5'h0F);
    ev(BR, EXT, 8'h6B);
    tick();
    chk_col("cmb_left_rel_5", 5'h1F);
    set_row(8'hFE);
    chk_col("cmb_caps_kept", 5'h1E);
    ev(BR, STD, 8'h12);
    tick();
    chk_col("cmb_caps_rel", 5'h1F);
    set_row(8'h7F);
    ev(MK, EXT, 8'h14);
    ev(MK, STD, 8'h41);
    tick();
    chk_col("cmb_comma", 5'h15);
    ev(BR, STD, 8'h41);
    tick();
    chk_col("cmb_sym_kept", 5'h1D);
    ev(BR, EXT, 8'h14);
    tick();
`endif

    // Asynchronous reset while NMI pulse is high.
    ev(MK, STD, 8'h03);
    tick();
    chk_bit("nmi_before_reset", nmi, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk_bit("nmi_async_reset", nmi, 1'b0);
    #1 reset = 1'b0;
    tick();

    // Asynchronous reset with an event in flight.
    set_row(8'hFD);
    ev(MK, STD, 8'h1C);
    tick();
    chk_col("hold_a", 5'h1E);
    ev(MK, STD, 8'h1B);
    set_row(8'h00);
    #3 reset = 1'b1;
    #1;
    chk_col("async_reset_col", 5'h1F);
    chk_bit("async_reset_nmi", nmi, 1'b0);
    chk_bit("async_reset_rst", rst_req, 1'b0);
    #2 reset = 1'b0;
    tick();
    tick();
    chk_col("inflight_dropped", 5'h1F);
    set_row(8'hFD);
    chk_col("inflight_dropped_a9", 5'h1F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
